// File: rtl/data_sync_hs.sv
// Multi-flop bus synchronizer: brings UNSYNC_BUS/BUS_EN into the CLK domain and
// presents the captured word through a valid/ready hold register with overrun tracking.
module data_sync_hs #(
   parameter int NUM_STAGES = 2,
   parameter int BUS_WIDTH  = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
   input  logic                 BUS_EN,
   output logic [BUS_WIDTH-1:0] SYNC_BUS,
   output logic                 ENABLE_PULSE,
   output logic                 VALID,
   input  logic                 READY,
   output logic                 OVERRUN,
   output logic [CNT_WIDTH-1:0] OVR_CNT,
   input  logic                 OVR_CLR
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [NUM_STAGES-1:0] sync_ff;
   logic                  edge_ff;
   logic                  sync_en;
   logic                  capture;
   logic                  overrun_evt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_ff <= '0;
         edge_ff <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[NUM_STAGES-2:0], BUS_EN};
         edge_ff <= sync_ff[NUM_STAGES-1];
      end
   end

   assign sync_en     = sync_ff[NUM_STAGES-1];
   assign capture     = sync_en & ~edge_ff;
   // Newest data wins; an overrun is a capture landing on unconsumed data.
   assign overrun_evt = capture & VALID & ~READY;

   // SYNC_BUS only ever loads on a capture, so a metastable raw bit never escapes.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         SYNC_BUS     <= '0;
         ENABLE_PULSE <= 1'b0;
         VALID        <= 1'b0;
      end else begin
         ENABLE_PULSE <= capture;
         if (capture) begin
            SYNC_BUS <= UNSYNC_BUS;
            VALID    <= 1'b1;
         end else if (VALID && READY) begin
            VALID    <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         OVERRUN <= 1'b0;
         OVR_CNT <= '0;
      end else if (overrun_evt) begin
         OVERRUN <= 1'b1;
         if (OVR_CLR)
            OVR_CNT <= CNT_ONE;
         else if (OVR_CNT != CNT_MAX)
            OVR_CNT <= OVR_CNT + CNT_ONE;
      end else if (OVR_CLR) begin
         OVERRUN <= 1'b0;
         OVR_CNT <= '0;
      end
   end

endmodule

// File: tb/tb_data_sync_hs.sv
// Scoreboard bench for data_sync_hs: each BUS_EN event pushes its expected output
// state; a negedge monitor pops and compares on every ENABLE_PULSE.
module tb_data_sync_hs;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] unsync_bus;
   logic       bus_en;
   logic [7:0] sync_bus;
   logic       enable_pulse;
   logic       valid;
   logic       ready;
   logic       overrun;
   logic [3:0] ovr_cnt;
   logic       ovr_clr;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       v;
      logic       o;
      logic [3:0] c;
   } exp_t;

   exp_t exp_q[$];

   data_sync_hs #(.NUM_STAGES(2), .BUS_WIDTH(8), .CNT_WIDTH(4)) dut (
      .CLK          (clk),
      .RST          (rst),
      .UNSYNC_BUS   (unsync_bus),
      .BUS_EN       (bus_en),
      .SYNC_BUS     (sync_bus),
      .ENABLE_PULSE (enable_pulse),
      .VALID        (valid),
      .READY        (ready),
      .OVERRUN      (overrun),
      .OVR_CNT      (ovr_cnt),
      .OVR_CLR      (ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_sync_bus"}, 32'(sync_bus), 0);
      check({name, "_pulse"},    32'(enable_pulse), 0);
      check({name, "_valid"},    32'(valid), 0);
      check({name, "_overrun"},  32'(overrun), 0);
      check({name, "_ovr_cnt"},  32'(ovr_cnt), 0);
   endtask

   // One BUS_EN event; READY/OVR_CLR are applied only on the capture edge (edge 3).
   task automatic ev(input logic [7:0] d, input bit rdy, input bit clr,
                     input bit e_ovr, input logic [3:0] e_cnt);
      exp_t e;
      @(posedge clk); #1;
      unsync_bus = d;
      bus_en     = 1'b1;
      e.d = d; e.v = 1'b1; e.o = e_ovr; e.c = e_cnt;
      exp_q.push_back(e);
      repeat (2) @(posedge clk); #1;
      ready   = rdy;
      ovr_clr = clr;
      @(posedge clk); #1;
      ready   = 1'b0;
      ovr_clr = 1'b0;
      bus_en  = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   always @(negedge clk) begin
      if (enable_pulse === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(sync_bus), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_sync_bus", 32'(sync_bus), 32'(e.d));
            check("sb_valid",    32'(valid),    32'(e.v));
            check("sb_overrun",  32'(overrun),  32'(e.o));
            check("sb_ovr_cnt",  32'(ovr_cnt),  32'(e.c));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; unsync_bus = '0; bus_en = 1'b0; ready = 1'b0; ovr_clr = 1'b0;

      // 1: reset, then READY toggling with nothing pending
      repeat (3) @(posedge clk); #1;
      check_all_zero("reset");
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         ready = ~ready;
         check("idle_valid", 32'(valid), 0);
         check("idle_pulse", 32'(enable_pulse), 0);
      end
      ready = 1'b0;
      repeat (2) @(posedge clk);

      // 2: latency and consume
      begin
         exp_t e;
         @(posedge clk); #1;
         unsync_bus = 8'hA5; bus_en = 1'b1;
         e.d = 8'hA5; e.v = 1'b1; e.o = 1'b0; e.c = 4'd0;
         exp_q.push_back(e);
         @(posedge clk); #1;
         check("lat_e1_pulse", 32'(enable_pulse), 0);
         check("lat_e1_valid", 32'(valid), 0);
         @(posedge clk); #1;
         check("lat_e2_pulse", 32'(enable_pulse), 0);
         check("lat_e2_valid", 32'(valid), 0);
         @(posedge clk); #1;
         check("lat_e3_pulse", 32'(enable_pulse), 1);
         @(posedge clk); #1;
         check("lat_e4_pulse", 32'(enable_pulse), 0);
         check("lat_e4_valid", 32'(valid), 1);
         ready = 1'b1;
         @(posedge clk); #1;
         ready = 1'b0;
         check("consume_valid", 32'(valid), 0);
         check("consume_hold",  32'(sync_bus), 32'hA5);
         repeat (5) @(posedge clk); #1;
         check("long_hold_one_pulse", 32'(exp_q.size()), 0);
         bus_en = 1'b0;
         repeat (4) @(posedge clk);
      end

      // 3: overrun and clear
      ev(8'h11, 1'b0, 1'b0, 1'b0, 4'd0);
      ev(8'h22, 1'b0, 1'b0, 1'b1, 4'd1);
      @(posedge clk); #1;
      ovr_clr = 1'b1;
      @(posedge clk); #1;
      ovr_clr = 1'b0;
      check("clr_overrun",  32'(overrun), 0);
      check("clr_ovr_cnt",  32'(ovr_cnt), 0);
      check("clr_valid",    32'(valid), 1);
      check("clr_sync_bus", 32'(sync_bus), 32'h22);

      // 4: capture coincident with READY on pending data
      ev(8'h33, 1'b1, 1'b0, 1'b0, 4'd0);
      ev(8'h44, 1'b1, 1'b0, 1'b0, 4'd0);
      @(posedge clk); #1;
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      check("drain_valid",    32'(valid), 0);
      check("drain_sync_bus", 32'(sync_bus), 32'h44);

      // 5: saturation, then clear coincident with an overrun
      for (int i = 1; i <= 20; i++) begin
         if (i == 1) ev(8'h60 + 8'(i), 1'b0, 1'b0, 1'b0, 4'd0);
         else        ev(8'h60 + 8'(i), 1'b0, 1'b0, 1'b1, (i - 1 > 15) ? 4'd15 : 4'(i - 1));
      end
      check("sat_ovr_cnt", 32'(ovr_cnt), 15);
      ev(8'h75, 1'b0, 1'b1, 1'b1, 4'd1);

      // 6a: reset mid-fill with BUS_EN held high afterwards
      begin
         exp_t e;
         @(posedge clk); #1;
         unsync_bus = 8'h5A; bus_en = 1'b1;
         @(posedge clk); #3;
         rst = 1'b0;
         #1;
         check_all_zero("async_rst");
         @(posedge clk); #1;
         e.d = 8'h5A; e.v = 1'b1; e.o = 1'b0; e.c = 4'd0;
         exp_q.push_back(e);
         rst = 1'b1;
         repeat (6) @(posedge clk); #1;
         check("refill_one_pulse", 32'(exp_q.size()), 0);
         bus_en = 1'b0;
         repeat (4) @(posedge clk);
      end

      // 6b: reset mid-fill with BUS_EN dropped: no pulse may appear
      @(posedge clk); #1;
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      unsync_bus = 8'h77; bus_en = 1'b1;
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      bus_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (10) @(posedge clk); #1;
      check("noevent_valid",    32'(valid), 0);
      check("noevent_sync_bus", 32'(sync_bus), 0);

      repeat (3) @(posedge clk); #1;
      check("pending_pulses", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_sync_hs.md
Name: data_sync_hs

Overview:
- Multi-flop data-bus synchronizer: carries a bus and its qualifying enable from a foreign clock domain into the local CLK domain.
- Reset comes from the local reset synchronizer output, so RST here is that already-synchronized, asynchronously asserted reset.
- Sits directly downstream of the reset synchronizer. Feeds local consumers (UART TX, register file, etc.) through a valid/ready hold register with overrun detection.

Parameters:
- NUM_STAGES, 2, depth of the enable synchronizer flop chain (legal >= 2).
- BUS_WIDTH, 8, width of the data bus.
- CNT_WIDTH, 4, width of the saturating overrun counter.

Ports:
- CLK  in  1  local destination-domain clock, rising edge.
- RST  in  1  reset, asynchronous, active-low (driven by the synchronized reset).
- UNSYNC_BUS  in  BUS_WIDTH  source-domain data, quasi-static while BUS_EN is high.
- BUS_EN  in  1  source-domain level enable qualifying UNSYNC_BUS.
- SYNC_BUS  out  BUS_WIDTH  captured data, valid while VALID=1.
- ENABLE_PULSE  out  1  single-cycle strobe, asserted in the cycle new data appears on SYNC_BUS.
- VALID  out  1  SYNC_BUS holds unconsumed data.
- READY  in  1  consumer accepts SYNC_BUS on an edge where VALID&&READY.
- OVERRUN  out  1  sticky: new data arrived while previous data was unconsumed.
- OVR_CNT  out  CNT_WIDTH  saturating count of overrun events.
- OVR_CLR  in  1  synchronous clear of OVERRUN and OVR_CNT.

Behaviour:
- Reset (RST=0, asynchronous):
  - Sync chain, edge-detect flop, SYNC_BUS, ENABLE_PULSE, VALID, OVERRUN and OVR_CNT all go to 0 immediately, without waiting for a clock edge.
  - Reset mid-operation discards pending data.
- Enable sync:
  - BUS_EN passes through NUM_STAGES flops.
  - The last stage feeds an edge-detect flop.
  - Capture event = last_stage & ~edge_ff, i.e. a rising edge of the synchronized enable only.
- Latency:
  - BUS_EN is first sampled high at edge 1.
  - At edge NUM_STAGES+1, SYNC_BUS <= UNSYNC_BUS and ENABLE_PULSE <= 1.
  - ENABLE_PULSE returns to 0 at the next edge. Exactly one pulse per BUS_EN rising edge, however long BUS_EN is held.
- Source rules:
  - UNSYNC_BUS must be stable from BUS_EN rise for >= NUM_STAGES+2 destination cycles.
  - BUS_EN must be low for >= NUM_STAGES+1 cycles between events.
  - SYNC_BUS is never loaded except at a capture event, so no raw UNSYNC_BUS bit ever reaches the output.
- VALID handshake, evaluated at each edge:
  - capture && !VALID: VALID<=1.
  - capture && VALID && READY: VALID stays 1, new data loaded, no overrun.
  - capture && VALID && !READY: new data overwrites (newest wins), VALID stays 1, OVERRUN<=1, OVR_CNT increments.
  - !capture && VALID && READY: VALID<=0; SYNC_BUS holds its last value.
  - READY while VALID=0: ignored.
- Overrun counter:
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - OVR_CLR clears OVERRUN and OVR_CNT to 0 at the edge.
  - OVR_CLR coincident with an overrun event: the event wins, giving OVERRUN=1, OVR_CNT=1.
- All outputs are registered; no combinational path from input to output.

Test Plan:
1. Reset release, NUM_STAGES=2, BUS_EN=0 -> all outputs 0; READY toggling causes no VALID change.
2. UNSYNC_BUS=0xA5, BUS_EN high at edge 1, held 10 cycles -> SYNC_BUS=0xA5, ENABLE_PULSE=1 only after edge 3, VALID=1; READY=1 at edge 5 -> VALID=0 after edge 5, SYNC_BUS stays 0xA5.
3. Event 0x11 not consumed, then event 0x22 with READY=0 -> SYNC_BUS=0x22, VALID=1, OVERRUN=1, OVR_CNT=1. Then OVR_CLR pulse -> OVERRUN=0, OVR_CNT=0.
4. Capture edge coincident with READY=1 on pending 0x33, new data 0x44 -> VALID stays 1, SYNC_BUS=0x44, OVERRUN stays 0.
5. 20 unconsumed events, CNT_WIDTH=4 -> OVR_CNT saturates at 15. OVR_CLR in the same cycle as the 21st event -> OVR_CNT=1, OVERRUN=1.
6. RST asserted 1 cycle after BUS_EN rise (chain partially filled) -> outputs 0 asynchronously. After release, with BUS_EN still high, chain refills and one pulse occurs; with BUS_EN low, no pulse ever appears.
